fpcvt_pipe: RTL and testbench

Pipelined, parametrised converter from a two's-complement integer to a compact sign/exponent/significand float, where value = significand * 2^exponent. It generalises the combinational magnitude-to-float converter with configurable widths, round-half-up with renormalisation, saturation, and valid/ready flow control. It sits between a sample source and any consumer of compressed float codes, and supports back-to-back throughput.

---
 rtl/fpcvt_pipe.sv | 167 ++++++++++++++++
 tb/tb_fpcvt_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpcvt_pipe.sv
// fpcvt_pipe: three-stage pipelined two's-complement integer to
// sign/exponent/significand float converter (value = sig * 2^exp), with
// round-half-up, renormalisation, saturation and valid/ready flow control.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid/in_ready    input handshake, in_data two's-complement sample
//   out_valid/out_ready  output handshake
//   out_sign/out_exp/out_sig/out_sat  converted result and saturation flag
//   sat_cnt              saturating count of saturated results handed off
module fpcvt_pipe #(
  parameter int IN_W     = 12,
  parameter int EXP_W    = 3,
  parameter int SIG_W    = 4,
  parameter int ROUND_EN = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic [EXP_W-1:0]   out_exp,
  output logic [SIG_W-1:0]   out_sig,
  output logic               out_sat,
  output logic [CNT_W-1:0]   sat_cnt
);
  localparam int M    = IN_W - 1;
  localparam int EMAX = (1 << EXP_W) - 1;
  // One spare exponent bit so round-up past EMAX is visible to the sat test.
  localparam int EW   = EXP_W + 1;

  if (M > SIG_W + EMAX || SIG_W < 2) begin : g_bad_params
    $error("fpcvt_pipe: illegal parameter combination");
  end

  // ---------------- flow control ----------------
  logic [3:1] vld_q, vld_d, ld;
  logic [4:1] rdy;

  always_comb begin
    rdy[4] = out_ready;
    for (int k = 3; k >= 1; k--) rdy[k] = !vld_q[k] | rdy[k+1];
    in_ready = rst_n & rdy[1];
    ld[1]    = in_valid & in_ready;
    ld[2]    = vld_q[1] & rdy[2];
    ld[3]    = vld_q[2] & rdy[3];
    // A stage stays full if it holds data that cannot move on.
    for (int k = 1; k <= 3; k++) vld_d[k] = ld[k] | (vld_q[k] & !rdy[k+1]);
  end

  // ---------------- S1: sign / magnitude ----------------
  logic            sign1_d, sign1_q, fsat1_d, fsat1_q;
  logic [M-1:0]    mag1_d, mag1_q;
  logic [IN_W-1:0] neg;

  always_comb begin
    neg     = -in_data;
    sign1_d = in_data[IN_W-1];
    // The most negative input has no M-bit magnitude: clamp and force sat.
    fsat1_d = sign1_d & (in_data[M-1:0] == '0);
    mag1_d  = sign1_d ? neg[M-1:0] : in_data[M-1:0];
    if (fsat1_d) mag1_d = '1;
  end

  // ---------------- S2: normalise ----------------
  logic             sign2_q, fsat2_q, r2_d, r2_q;
  logic [EW-1:0]    e2_d, e2_q;
  logic [SIG_W-1:0] s2_d, s2_q;
  logic [M-1:0]     sh;
  int               p, e_int;

  always_comb begin
    p = 0;
    for (int i = 0; i < M; i++) if (mag1_q[i]) p = i;
    e_int = (p > SIG_W - 1) ? p - (SIG_W - 1) : 0;
    e2_d  = EW'(e_int);
    s2_d  = SIG_W'(mag1_q >> e_int);
    // First discarded bit, mag[e-1]; none when nothing was shifted out.
    sh    = (e_int > 0) ? (mag1_q >> (e_int - 1)) : '0;
    r2_d  = sh[0];
  end

  // ---------------- S3: round / saturate ----------------
  logic             sign3_d, sat3_d, rnd;
  logic [EXP_W-1:0] exp3_d;
  logic [SIG_W-1:0] sig3_d;
  logic [SIG_W:0]   sum;
  logic [EW-1:0]    e3;

  always_comb begin
    rnd     = (ROUND_EN != 0) & r2_q;
    sum     = {1'b0, s2_q} + {{SIG_W{1'b0}}, rnd};
    e3      = e2_q;
    sig3_d  = sum[SIG_W-1:0];
    // Rounding carried out of the significand: renormalise to 2^(SIG_W-1).
    if (sum[SIG_W]) begin
      sig3_d = {1'b1, {(SIG_W-1){1'b0}}};
      e3     = e2_q + EW'(1);
    end
    sign3_d = sign2_q;
    sat3_d  = fsat2_q | (e3 > EW'(EMAX));
    exp3_d  = e3[EXP_W-1:0];
    if (sat3_d) begin
      exp3_d = EXP_W'(EMAX);
      sig3_d = '1;
    end
  end

  // ---------------- registers ----------------
  logic             out_sign_q, out_sat_q;
  logic [EXP_W-1:0] out_exp_q;
  logic [SIG_W-1:0] out_sig_q;
  logic [CNT_W-1:0] sat_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      sign1_q    <= 1'b0;
      fsat1_q    <= 1'b0;
      mag1_q     <= '0;
      sign2_q    <= 1'b0;
      fsat2_q    <= 1'b0;
      e2_q       <= '0;
      s2_q       <= '0;
      r2_q       <= 1'b0;
      out_sign_q <= 1'b0;
      out_exp_q  <= '0;
      out_sig_q  <= '0;
      out_sat_q  <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      vld_q <= vld_d;
      if (ld[1]) begin
        sign1_q <= sign1_d;
        fsat1_q <= fsat1_d;
        mag1_q  <= mag1_d;
      end
      if (ld[2]) begin
        sign2_q <= sign1_q;
        fsat2_q <= fsat1_q;
        e2_q    <= e2_d;
        s2_q    <= s2_d;
        r2_q    <= r2_d;
      end
      if (ld[3]) begin
        out_sign_q <= sign3_d;
        out_exp_q  <= exp3_d;
        out_sig_q  <= sig3_d;
        out_sat_q  <= sat3_d;
      end
      if (vld_q[3] & out_ready & out_sat_q & ~&sat_cnt_q)
        sat_cnt_q <= sat_cnt_q + CNT_W'(1);
    end
  end

  assign out_valid = vld_q[3];
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_sig   = out_sig_q;
  assign out_sat   = out_sat_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Bench for fpcvt_pipe: default-parameter instance (A) with directed,
// random-streaming and reset tests; ROUND_EN=0/CNT_W=2 instance (B) for
// truncation and counter saturation. Expected results come from a
// behavioural arithmetic model or hand-derived constants.
module tb_fpcvt_pipe;
  typedef struct packed {
    logic       sign;
    logic [2:0] exp;
    logic [3:0] sig;
    logic       sat;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // instance A (defaults)
  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [11:0] in_data_a;
  logic        out_sign_a, out_sat_a;
  logic [2:0]  out_exp_a;
  logic [3:0]  out_sig_a;
  logic [15:0] sat_cnt_a;
  // instance B (truncate, 2-bit counter)
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [11:0] in_data_b;
  logic        out_sign_b, out_sat_b;
  logic [2:0]  out_exp_b;
  logic [3:0]  out_sig_b;
  logic [1:0]  sat_cnt_b;

  fpcvt_pipe u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_sign(out_sign_a), .out_exp(out_exp_a), .out_sig(out_sig_a),
    .out_sat(out_sat_a), .sat_cnt(sat_cnt_a));

  fpcvt_pipe #(.ROUND_EN(0), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_sign(out_sign_b), .out_exp(out_exp_b), .out_sig(out_sig_b),
    .out_sat(out_sat_b), .sat_cnt(sat_cnt_b));

  int   n_chk = 0, n_err = 0;
  int   exp_sat_a = 0, exp_sat_b = 0;
  res_t qa[$], qb[$];
  res_t ea, eb, held_a;
  bit   stall_a = 0, rnd_rdy = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic res_t mk(input bit s, input int e, input int g, input bit t);
    res_t r;
    r.sign = s; r.exp = 3'(e); r.sig = 4'(g); r.sat = t;
    return r;
  endfunction

  // value = sig * 2^exp: pick the smallest exponent whose quotient fits in
  // 4 bits, then round the quotient to nearest (halves up).
  function automatic res_t model(input logic [11:0] d, input bit rnd);
    res_t r;
    int v, m, e, q;
    bit force_sat;
    v = int'($signed(d));
    m = (v < 0) ? -v : v;
    force_sat = (v == -2048);
    e = 0;
    while ((m >> e) >= 16) e++;
    if (rnd && e > 0) q = (m + (1 << (e - 1))) >> e;
    else              q = m >> e;
    if (q == 16) begin q = 8; e++; end
    r.sign = (v < 0);
    if (force_sat || e > 7) begin r.exp = 3'd7; r.sig = 4'd15; r.sat = 1'b1; end
    else begin r.exp = 3'(e); r.sig = 4'(q); r.sat = 1'b0; end
    return r;
  endfunction

  always @(negedge clk) if (rnd_rdy) out_ready_a = 1'($urandom_range(0, 1));

  // Monitor A: counter, in_ready occupancy rule, stall stability, results.
  always @(negedge clk) begin
    #1;
    if (!rst_n) stall_a = 0;
    else begin
      chk("satcnt_a", 32'(sat_cnt_a), 32'(exp_sat_a));
      chk("in_ready_a", 32'(in_ready_a), 32'(!(qa.size() == 3 && !out_ready_a)));
      if (stall_a && out_valid_a)
        chk("stable_a", 32'({out_sign_a, out_exp_a, out_sig_a, out_sat_a}), 32'(held_a));
      if (out_valid_a && out_ready_a) begin
        if (qa.size() == 0) chk("spurious_a", 32'(qa.size()), 32'd1);
        else begin
          ea = qa.pop_front();
          chk("out_a", 32'({out_sign_a, out_exp_a, out_sig_a, out_sat_a}), 32'(ea));
          if (ea.sat && exp_sat_a < 65535) exp_sat_a++;
        end
      end
      stall_a = out_valid_a && !out_ready_a;
      held_a  = {out_sign_a, out_exp_a, out_sig_a, out_sat_a};
    end
  end

  // Monitor B: always-ready consumer.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      chk("satcnt_b", 32'(sat_cnt_b), 32'(exp_sat_b));
      if (out_valid_b) begin
        if (qb.size() == 0) chk("spurious_b", 32'(qb.size()), 32'd1);
        else begin
          eb = qb.pop_front();
          chk("out_b", 32'({out_sign_b, out_exp_b, out_sig_b, out_sat_b}), 32'(eb));
          if (eb.sat && exp_sat_b < 3) exp_sat_b++;
        end
      end
    end
  end

  // All tasks start and end at a falling edge.
  task automatic send_a(input logic [11:0] d, input res_t e);
    in_valid_a = 1'b1; in_data_a = d;
    for (int i = 0; i < 200; i++) begin
      #2;
      if (in_ready_a) begin
        qa.push_back(e);
        @(negedge clk);
        in_valid_a = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("accept_timeout_a", 32'd0, 32'd1);
    in_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [11:0] d, input res_t e);
    in_valid_b = 1'b1; in_data_b = d;
    for (int i = 0; i < 200; i++) begin
      #2;
      if (in_ready_b) begin
        qb.push_back(e);
        @(negedge clk);
        in_valid_b = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("accept_timeout_b", 32'd0, 32'd1);
    in_valid_b = 1'b0;
  endtask

  task automatic drain(input bit which_b);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      #3;
      if ((which_b ? qb.size() : qa.size()) == 0) break;
    end
    if (i == 300) chk("drain_timeout", 32'(which_b ? qb.size() : qa.size()), 32'd0);
    @(negedge clk);
    #3;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] d;
    rst_n = 1'b0;
    in_valid_a = 0; in_data_a = '0; out_ready_a = 1'b1;
    in_valid_b = 0; in_data_b = '0; out_ready_b = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_valid", 32'(out_valid_a), 32'd0);
    chk("rst_ready", 32'(in_ready_a), 32'd0);
    chk("rst_fields", 32'({out_sign_a, out_exp_a, out_sig_a, out_sat_a}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // latency of a single sample
    send_a(12'd7, mk(0, 0, 7, 0));
    #3 chk("lat1", 32'(out_valid_a), 32'd0);
    @(negedge clk);
    #3 chk("lat2", 32'(out_valid_a), 32'd0);
    @(negedge clk);
    #3 chk("lat3", 32'(out_valid_a), 32'd1);
    @(negedge clk);
    drain(0);

    // rounding, renormalisation, saturation, negatives
    send_a(12'd422,      mk(0, 5, 13, 0));
    send_a(12'd56,       mk(0, 2, 14, 0));
    send_a(12'd125,      mk(0, 4, 8, 0));
    send_a(12'd2047,     mk(0, 7, 15, 1));
    send_a(12'h800,      mk(1, 7, 15, 1));
    send_a(12'(-422),    mk(1, 5, 13, 0));
    send_a(12'd0,        mk(0, 0, 0, 0));
    drain(0);
    chk("satcnt_two", 32'(sat_cnt_a), 32'd2);

    // random stream, random back-pressure
    rnd_rdy = 1;
    for (int i = 0; i < 20; i++) begin
      case (i % 5)
        0:       d = 12'h800;
        1:       d = 12'($urandom_range(0, 31));
        default: d = 12'($urandom);
      endcase
      send_a(d, model(d, 1'b1));
    end
    drain(0);
    rnd_rdy = 0;
    out_ready_a = 1'b1;

    // fill pipe under stall, then reset mid-stream
    out_ready_a = 1'b0;
    for (int i = 0; i < 3; i++) send_a(12'h800, mk(1, 7, 15, 1));
    #3;
    chk("full_ready", 32'(in_ready_a), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid_a), 32'd0);
    chk("midrst_satcnt", 32'(sat_cnt_a), 32'd0);
    chk("midrst_ready", 32'(in_ready_a), 32'd0);
    qa.delete();
    exp_sat_a = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #3 chk("stale", 32'(out_valid_a), 32'd0);
      @(negedge clk);
    end

    // instance B: truncation and 2-bit counter saturation
    send_b(12'd125, mk(0, 3, 15, 0));
    for (int i = 0; i < 5; i++) send_b(12'h800, mk(1, 7, 15, 1));
    drain(1);
    chk("satcnt_b_max", 32'(sat_cnt_b), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
